// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - round-robin arbitrating mux with registered valid/ready output stage
// Optional burst lock via ARB_MUX_LOCK_EN (in_last holds the grant until the last beat).
module rr_arb_mux #(
   parameter  int N     = 8,
   parameter  int WIDTH = 32,
   localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N-1:0]         i_in_valid,
   input  logic [N*WIDTH-1:0]   i_in_data,
   output logic [N-1:0]         o_in_ready,
   input  logic [N-1:0]         i_in_last,
   output logic                 o_out_valid,
   output logic [WIDTH-1:0]     o_out_data,
   output logic [SELW-1:0]      o_out_sel,
   output logic                 o_out_last,
   input  logic                 i_out_ready
);

   logic [SELW-1:0]  r_ptr;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_sel;

   logic             w_found;
   logic [SELW-1:0]  w_gnt;
   logic [SELW:0]    w_idx;
   logic             w_load;
   logic             w_xfer;
   logic [WIDTH-1:0] w_gnt_data;
   logic [SELW-1:0]  w_ptr_next;

`ifdef ARB_MUX_LOCK_EN
   logic             r_lock;
   logic [SELW-1:0]  r_lock_sel;
   logic             r_out_last;
`else
   logic             w_unused_last;
   assign w_unused_last = ^i_in_last;
`endif

   // Search ptr, ptr+1, ... with wrap at N (N need not be a power of two).
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
`ifdef ARB_MUX_LOCK_EN
      if (r_lock) begin
         w_found = i_in_valid[r_lock_sel];
         w_gnt   = r_lock_sel;
      end else
`endif
      begin
         for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (SELW+1)'(k);
            if (w_idx >= (SELW+1)'(N))
               w_idx = w_idx - (SELW+1)'(N);
            if (!w_found && i_in_valid[w_idx[SELW-1:0]]) begin
               w_found = 1'b1;
               w_gnt   = w_idx[SELW-1:0];
            end
         end
      end
   end

   always_comb begin
      w_gnt_data = '0;
      for (int i = 0; i < N; i++)
         if (w_gnt == SELW'(i))
            w_gnt_data = i_in_data[i*WIDTH +: WIDTH];
   end

   assign w_load     = !r_out_valid || i_out_ready;
   assign w_xfer     = w_load && w_found;
   assign w_ptr_next = (w_gnt == SELW'(N-1)) ? '0 : w_gnt + SELW'(1);

   always_comb begin
      o_in_ready = '0;
      if (w_xfer)
         o_in_ready[w_gnt] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
`ifdef ARB_MUX_LOCK_EN
         r_lock      <= 1'b0;
         r_lock_sel  <= '0;
         r_out_last  <= 1'b0;
`endif
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_gnt_data;
         r_out_sel   <= w_gnt;
`ifdef ARB_MUX_LOCK_EN
         r_out_last  <= i_in_last[w_gnt];
         if (i_in_last[w_gnt]) begin
            r_lock <= 1'b0;
            r_ptr  <= w_ptr_next;
         end else begin
            r_lock     <= 1'b1;
            r_lock_sel <= w_gnt;
         end
`else
         r_ptr       <= w_ptr_next;
`endif
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_sel   = r_out_sel;
`ifdef ARB_MUX_LOCK_EN
   assign o_out_last  = r_out_last;
`else
   assign o_out_last  = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - scoreboard bench for rr_arb_mux (N=8 and N=3 instances)
module tb_rr_arb_mux;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    valid8, last8, ready8_o;
   logic [255:0]  data8;
   logic          ready8, ovalid8, olast8;
   logic [31:0]   odata8;
   logic [2:0]    osel8;
   logic [2:0]    valid3, last3, ready3_o;
   logic [47:0]   data3;
   logic          ready3, ovalid3, olast3;
   logic [15:0]   odata3;
   logic [1:0]    osel3;

   typedef struct packed { logic [2:0] sel; logic [31:0] data; logic last; } exp8_t;
   typedef struct packed { logic [1:0] sel; logic [15:0] data; } exp3_t;
   exp8_t q8[$];
   exp3_t q3[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_arb_mux #(.N(8), .WIDTH(32)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(valid8), .i_in_data(data8),
      .o_in_ready(ready8_o), .i_in_last(last8), .o_out_valid(ovalid8),
      .o_out_data(odata8), .o_out_sel(osel8), .o_out_last(olast8), .i_out_ready(ready8));

   rr_arb_mux #(.N(3), .WIDTH(16)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(valid3), .i_in_data(data3),
      .o_in_ready(ready3_o), .i_in_last(last3), .o_out_valid(ovalid3),
      .o_out_data(odata3), .o_out_sel(osel3), .o_out_last(olast3), .i_out_ready(ready3));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push8(input int s, input logic l);
      exp8_t e;
      e.sel = 3'(s); e.data = 32'hA0 + 32'(s); e.last = l;
      q8.push_back(e);
   endtask

   task automatic push3(input int s);
      exp3_t e;
      e.sel = 2'(s); e.data = 16'hB0 + 16'(s);
      q3.push_back(e);
   endtask

   task automatic monitor();
      exp8_t e8;
      exp3_t e3;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ovalid8 && ready8) begin
               if (q8.size() == 0) chk("sb8_unexpected", {29'd0, osel8}, 64'hFFFF);
               else begin
                  e8 = q8.pop_front();
                  chk("sb8_word", {osel8, odata8, olast8}, {e8.sel, e8.data, e8.last});
               end
            end
            if (ovalid3 && ready3) begin
               if (q3.size() == 0) chk("sb3_unexpected", {30'd0, osel3}, 64'hFFFF);
               else begin
                  e3 = q3.pop_front();
                  chk("sb3_word", {osel3, odata3}, {e3.sel, e3.data});
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      valid8 = '0; last8 = '0; ready8 = 1'b0;
      valid3 = '0; last3 = '0; ready3 = 1'b0;
      for (int i = 0; i < 8; i++) data8[i*32 +: 32] = 32'hA0 + 32'(i);
      for (int i = 0; i < 3; i++) data3[i*16 +: 16] = 16'hB0 + 16'(i);
      @(negedge clk);
      chk("rst_valid", 64'(ovalid8), 64'd0);
      chk("rst_sel", 64'(osel8), 64'd0);
      chk("rst_data", 64'(odata8), 64'd0);
      chk("rst_last", 64'(olast8), 64'd0);
      chk("rst_valid3", 64'(ovalid3), 64'd0);
      fork monitor(); join_none
      tick();
      rst_n = 1'b1;

      // reset mid-stall drops the held word and the pointer
      valid8 = 8'h08;
      tick();
      valid8 = 8'h00;
      chk("t1_loaded", {61'd0, ovalid8, osel8}, {61'd0, 1'b1, 3'd3});
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_valid", 64'(ovalid8), 64'd0);
      chk("t1_rst_ready", 64'(ready8_o), 64'd0);
      tick();
      rst_n = 1'b1;
      valid8 = 8'h21; ready8 = 1'b1;
      push8(0, 1'b0); push8(5, 1'b0);
      tick(); tick();
      valid8 = 8'h00;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // all channels valid: strict rotation at one word per clock
      valid8 = 8'hFF;
      for (int i = 0; i < 8; i++) push8(i, 1'b0);
      push8(0, 1'b0);
      repeat (9) tick();
      valid8 = 8'h00;
      chk("t2_throughput", 64'(q8.size()), 64'd1);
      tick();

      // stall with channels 2 and 5 pending
      valid8 = 8'h24; ready8 = 1'b0;
      tick();
      valid8 = 8'h20;
      push8(2, 1'b0); push8(5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_stall_sel", {29'd0, ovalid8, osel8}, {29'd0, 1'b1, 3'd2});
         chk("t3_stall_data", 64'(odata8), 64'hA2);
         chk("t3_stall_ready", 64'(ready8_o), 64'd0);
         tick();
      end
      ready8 = 1'b1;
      tick();
      valid8 = 8'h00;
      tick();

      // single word then idle
      valid8 = 8'h80;
      push8(7, 1'b0);
      tick();
      valid8 = 8'h00;
      @(negedge clk);
      chk("t5_valid", 64'(ovalid8), 64'd1);
      tick();
      @(negedge clk);
      chk("t5_drop", 64'(ovalid8), 64'd0);
      chk("t5_sel_hold", 64'(osel8), 64'd7);

      // N=3 wrap from 2 back to 0
      tick();
      valid3 = 3'b100; ready3 = 1'b1;
      push3(2);
      tick();
      valid3 = 3'b101;
      push3(0); push3(2);
      tick(); tick();
      valid3 = 3'b000;
      tick();

`ifdef ARB_MUX_LOCK_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      valid8 = 8'h02; last8 = 8'h00;
      push8(1, 1'b0); push8(1, 1'b0); push8(1, 1'b0); push8(1, 1'b1); push8(0, 1'b0);
      tick();
      valid8 = 8'h03;
      tick(); tick();
      last8 = 8'h02;
      tick();
      last8 = 8'h00;
      tick();
      valid8 = 8'h00;
      tick();
`endif

      for (int i = 0; i < 20 && (q8.size() != 0 || q3.size() != 0); i++) tick();
      tick();
      chk("sb8_empty", 64'(q8.size()), 64'd0);
      chk("sb3_empty", 64'(q3.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
